multicycle_sequencer: RTL and testbench

- Sequencing FSM for the 16-bit multicycle RISC core. Sits directly downstream of the combinational opcode decoder and consumes its decoded control bits.
- Steps each instruction through IF/ID/EX/MEM/WB.
- Issues per-cycle strobes: PC write, IR write, register write, memory read/write, ALU latch.
- Handles ready handshakes to instruction and data memory.

---
 rtl/multicycle_sequencer_pkg.sv | 45 ++++
 rtl/multicycle_sequencer_if.sv | 38 +++
 rtl/multicycle_sequencer_wait_timer.sv | 27 ++
 rtl/multicycle_sequencer.sv | 158 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// cpu_pkg: opcodes, sequencer state encodings and PC source selects shared
// by the multicycle core sequencer, its wait timer and the datapath.
// No ports; pure type/constant package.
package cpu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ANDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_LB   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BGT  = 4'd8;
  localparam logic [3:0] OP_BLT  = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_SV   = 4'd15;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd7
  } state_t;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_REG = 2'b11;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BGT) || (op == OP_BLT) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> datapath/memory bundle: decoded control and readies in,
// per-cycle strobes, sticky bus error and debug state out.
// master = sequencer side, slave = datapath/memory/test side.
interface multicycle_sequencer_if;
  logic [3:0] op;
  logic       ctl_reg_wr;
  logic       ctl_mem_rd;
  logic       ctl_mem_wr;
  logic       zero;
  logic       negative;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_rd;
  logic       ir_wr;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       alu_en;
  logic       dmem_rd;
  logic       dmem_wr;
  logic       reg_wr;
  logic       instr_done;
  logic       bus_err;
  logic [2:0] state;

  modport master (
    input  op, ctl_reg_wr, ctl_mem_rd, ctl_mem_wr, zero, negative,
           imem_ready, dmem_ready,
    output imem_rd, ir_wr, pc_wr, pc_src, alu_en, dmem_rd, dmem_wr,
           reg_wr, instr_done, bus_err, state
  );

  modport slave (
    output op, ctl_reg_wr, ctl_mem_rd, ctl_mem_wr, zero, negative,
           imem_ready, dmem_ready,
    input  imem_rd, ir_wr, pc_wr, pc_src, alu_en, dmem_rd, dmem_wr,
           reg_wr, instr_done, bus_err, state
  );
endinterface

// File: rtl/multicycle_sequencer_wait_timer.sv
// seq_wait_timer: counts consecutive not-ready cycles of a memory wait.
// Ports: clk, reset_n, wait_req (waiting this cycle), timeout (pulse).
// timeout fires combinationally on the MEM_TIMEOUT-th wait cycle; 0 disables.
module seq_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic wait_req,
  output logic timeout
);
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign cnt_nxt = cnt + 1'b1;
  // cnt holds waits already seen, so compare the count including this cycle
  assign timeout = (MEM_TIMEOUT != 0) && wait_req && (cnt_nxt == CW'(MEM_TIMEOUT));

  // Any non-wait cycle is either a ready or a state change, both clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  cnt <= '0;
    else if (wait_req && !timeout) cnt <= cnt_nxt;
    else                           cnt <= '0;
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: IF/ID/EX/MEM/WB sequencing FSM for the 16-bit core.
// Ports: clk, reset_n, bus (multicycle_sequencer_if.master); with
// MULTICYCLE_PERF_EN defined also perf_cycles/perf_instrs[PERF_W-1:0].
// Strobes are combinational from state/op/flags/ready and forced low in reset.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
`ifdef MULTICYCLE_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic clk,
  input  logic reset_n,
`ifdef MULTICYCLE_PERF_EN
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_instrs,
`endif
  multicycle_sequencer_if.master bus
);
  state_t     st;
  logic       bus_err_q;
  logic       waiting, timeout, taken;
  logic       imem_rd, ir_wr, pc_wr, alu_en, dmem_rd, dmem_wr, reg_wr, done;
  logic [1:0] pc_src;

  assign waiting = ((st == ST_IF)  && !bus.imem_ready) ||
                   ((st == ST_MEM) && !bus.dmem_ready);

  seq_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .wait_req (waiting),
    .timeout  (timeout)
  );

  always_comb begin
    taken = 1'b0;
    case (bus.op)
      OP_BGT:  taken = !bus.zero && !bus.negative;
      OP_BLT:  taken = bus.negative;
      OP_BEQ:  taken = bus.zero;
      OP_BNE:  taken = !bus.zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    imem_rd = 1'b0; ir_wr = 1'b0; pc_wr = 1'b0; pc_src = PCSRC_INC;
    alu_en = 1'b0; dmem_rd = 1'b0; dmem_wr = 1'b0; reg_wr = 1'b0; done = 1'b0;
    case (st)
      ST_IF: begin
        imem_rd = 1'b1;
        if (bus.imem_ready) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
      end
      ST_ID: begin
        case (bus.op)
          OP_JMP:  begin pc_wr = 1'b1; pc_src = PCSRC_JMP; done = 1'b1; end
          OP_RET:  begin pc_wr = 1'b1; pc_src = PCSRC_REG; done = 1'b1; end
          OP_CALL: begin pc_wr = 1'b1; pc_src = PCSRC_JMP; end
          default: ;
        endcase
      end
      ST_EX: begin
        alu_en = 1'b1;
        if (is_branch(bus.op)) begin
          pc_wr  = taken;
          pc_src = PCSRC_BR;
          done   = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_rd = bus.ctl_mem_rd;
        dmem_wr = bus.ctl_mem_wr;
        if (bus.dmem_ready && !is_load(bus.op)) done = 1'b1;
      end
      ST_WB: begin
        reg_wr = bus.ctl_reg_wr;
        done   = 1'b1;
      end
      default: ;
    endcase
    // Strobes are decoded from the reset state, so mask them while in reset.
    if (!reset_n) begin
      imem_rd = 1'b0; ir_wr = 1'b0; pc_wr = 1'b0; pc_src = PCSRC_INC;
      alu_en = 1'b0; dmem_rd = 1'b0; dmem_wr = 1'b0; reg_wr = 1'b0; done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= ST_IF;
      bus_err_q <= 1'b0;
    end else begin
      case (st)
        ST_IF: begin
          if (timeout) begin
            st        <= ST_HALT;
            bus_err_q <= 1'b1;
          end else if (bus.imem_ready) begin
            st <= ST_ID;
          end
        end
        ST_ID: begin
          case (bus.op)
            OP_JMP, OP_RET: st <= ST_IF;
            OP_CALL:        st <= ST_WB;
            OP_SV:          st <= ST_MEM;
            default:        st <= ST_EX;
          endcase
        end
        ST_EX: begin
          if (is_branch(bus.op))                                      st <= ST_IF;
          else if (is_load(bus.op) || (bus.op == OP_SW))              st <= ST_MEM;
          else                                                        st <= ST_WB;
        end
        ST_MEM: begin
          if (timeout) begin
            st        <= ST_HALT;
            bus_err_q <= 1'b1;
          end else if (bus.dmem_ready) begin
            st <= is_load(bus.op) ? ST_WB : ST_IF;
          end
        end
        ST_WB:   st <= ST_IF;
        ST_HALT: st <= ST_HALT;
        default: st <= ST_IF;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
      perf_instrs <= '0;
    end else begin
      if (st != ST_HALT) perf_cycles <= perf_cycles + 1'b1;
      if (done)          perf_instrs <= perf_instrs + 1'b1;
    end
  end
`endif

  assign bus.imem_rd    = imem_rd;
  assign bus.ir_wr      = ir_wr;
  assign bus.pc_wr      = pc_wr;
  assign bus.pc_src     = pc_src;
  assign bus.alu_en     = alu_en;
  assign bus.dmem_rd    = dmem_rd;
  assign bus.dmem_wr    = dmem_wr;
  assign bus.reg_wr     = reg_wr;
  assign bus.instr_done = done;
  assign bus.bus_err    = bus_err_q;
  assign bus.state      = st;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-cycle expected output vectors are queued
// as stimulus is driven and compared on the falling edge.
// MEM_TIMEOUT=4; perf counters checked when MULTICYCLE_PERF_EN is defined.
module tb_multicycle_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_rd, ir_wr, pc_wr;
    logic [1:0] pc_src;
    logic       alu_en, dmem_rd, dmem_wr, reg_wr, done, berr;
  } vec_t;

  typedef struct {
    string tag;
    vec_t  v;
  } exp_item_t;

  typedef struct packed {
    logic [3:0] op;
    logic       z, n, tk;
  } br_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_item_t exp_q[$];

  multicycle_sequencer_if bus();

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] perf_cycles, perf_instrs;
`endif

  multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef MULTICYCLE_PERF_EN
    .perf_cycles (perf_cycles),
    .perf_instrs (perf_instrs),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // flags: [7]imem_rd [6]ir_wr [5]pc_wr [4]alu_en [3]dmem_rd [2]dmem_wr [1]reg_wr [0]instr_done
  function automatic vec_t ev(input logic [2:0] st, input logic [7:0] f,
                              input logic [1:0] src, input logic berr);
    vec_t v;
    v = {st, f[7], f[6], f[5], src, f[4], f[3], f[2], f[1], f[0], berr};
    return v;
  endfunction

  function automatic vec_t observe();
    vec_t v;
    v = {bus.state, bus.imem_rd, bus.ir_wr, bus.pc_wr, bus.pc_src, bus.alu_en,
         bus.dmem_rd, bus.dmem_wr, bus.reg_wr, bus.instr_done, bus.bus_err};
    return v;
  endfunction

  // pc_src only matters when the PC is actually written
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_item_t it;
      vec_t o;
      it = exp_q.pop_front();
      o  = observe();
      if (!it.v.pc_wr) o.pc_src = it.v.pc_src;
      chk(it.tag, {17'b0, o}, {17'b0, it.v});
    end
  end

  task automatic step(input string tag, input vec_t v);
    exp_item_t it;
    it.tag = tag;
    it.v   = v;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic rw, input logic mr,
                        input logic mw, input logic z, input logic n,
                        input logic ir, input logic dr);
    bus.op = op; bus.ctl_reg_wr = rw; bus.ctl_mem_rd = mr; bus.ctl_mem_wr = mw;
    bus.zero = z; bus.negative = n; bus.imem_ready = ir; bus.dmem_ready = dr;
  endtask

  task automatic run_add(input string pfx);
    set_in(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step({pfx, "_if"}, ev(3'd0, 8'b1110_0000, PCSRC_INC, 1'b0));
    step({pfx, "_id"}, ev(3'd1, 8'b0000_0000, PCSRC_INC, 1'b0));
    step({pfx, "_ex"}, ev(3'd2, 8'b0001_0000, PCSRC_INC, 1'b0));
    step({pfx, "_wb"}, ev(3'd4, 8'b0000_0011, PCSRC_INC, 1'b0));
  endtask

  vec_t FETCH, ID0, EXA, WBR, MEMRD, MEMWR_W, HALTV;
  br_t  br_tab[6];

  initial begin
    FETCH   = ev(3'd0, 8'b1110_0000, PCSRC_INC, 1'b0);
    ID0     = ev(3'd1, 8'b0000_0000, PCSRC_INC, 1'b0);
    EXA     = ev(3'd2, 8'b0001_0000, PCSRC_INC, 1'b0);
    WBR     = ev(3'd4, 8'b0000_0011, PCSRC_INC, 1'b0);
    MEMRD   = ev(3'd3, 8'b0000_1000, PCSRC_INC, 1'b0);
    MEMWR_W = ev(3'd3, 8'b0000_0100, PCSRC_INC, 1'b0);
    HALTV   = ev(3'd7, 8'b0000_0000, PCSRC_INC, 1'b1);
    br_tab = '{ '{OP_BEQ, 1'b1, 1'b0, 1'b1}, '{OP_BEQ, 1'b0, 1'b0, 1'b0},
                '{OP_BGT, 1'b0, 1'b0, 1'b1}, '{OP_BGT, 1'b1, 1'b0, 1'b0},
                '{OP_BLT, 1'b0, 1'b1, 1'b1}, '{OP_BNE, 1'b1, 1'b0, 1'b0} };

    // reset: readies high, yet nothing may strobe
    reset_n = 1'b0;
    set_in(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    step("reset", ev(3'd0, 8'b0000_0000, PCSRC_INC, 1'b0));
    reset_n = 1'b1;

    // ADD then JMP (6 cycles, 2 instructions)
    run_add("add");
    set_in(OP_JMP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("jmp_if", FETCH);
    step("jmp_id", ev(3'd1, 8'b0010_0001, PCSRC_JMP, 1'b0));
`ifdef MULTICYCLE_PERF_EN
    chk("perf_cycles", perf_cycles, 32'd6);
    chk("perf_instrs", perf_instrs, 32'd2);
`endif

    // LW with three data wait cycles: 8 cycles total
    set_in(OP_LW, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("lw_if", FETCH);
    step("lw_id", ID0);
    step("lw_ex", EXA);
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw_mem_wait", MEMRD);
    bus.dmem_ready = 1'b1;
    step("lw_mem_rdy", MEMRD);
    step("lw_wb", WBR);

    // branches: taken/not-taken table
    for (int i = 0; i < 6; i++) begin
      set_in(br_tab[i].op, 1'b0, 1'b0, 1'b0, br_tab[i].z, br_tab[i].n, 1'b1, 1'b1);
      step("br_if", FETCH);
      step("br_id", ID0);
      step("br_ex", ev(3'd2, {2'b00, br_tab[i].tk, 5'b1_0001}, PCSRC_BR, 1'b0));
    end

    // CALL then RET
    set_in(OP_CALL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("call_if", FETCH);
    step("call_id", ev(3'd1, 8'b0010_0000, PCSRC_JMP, 1'b0));
    step("call_wb", WBR);
    set_in(OP_RET, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("ret_if", FETCH);
    step("ret_id", ev(3'd1, 8'b0010_0001, PCSRC_REG, 1'b0));

    // SV (3 cycles) and SW (4 cycles), no waits
    set_in(OP_SV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step("sv_if", FETCH);
    step("sv_id", ID0);
    step("sv_mem", ev(3'd3, 8'b0000_0101, PCSRC_INC, 1'b0));
    set_in(OP_SW, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step("sw_if", FETCH);
    step("sw_id", ID0);
    step("sw_ex", EXA);
    step("sw_mem", ev(3'd3, 8'b0000_0101, PCSRC_INC, 1'b0));

    // instruction fetch waits below the timeout
    set_in(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("if_wait", ev(3'd0, 8'b1000_0000, PCSRC_INC, 1'b0));
    bus.imem_ready = 1'b1;
    step("ifw_if", FETCH);
    step("ifw_id", ID0);
    step("ifw_ex", EXA);
    step("ifw_wb", WBR);

    // SW with data ready stuck low: HALT after 4 wait cycles
    set_in(OP_SW, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("to_if", FETCH);
    step("to_id", ID0);
    step("to_ex", EXA);
    for (int i = 0; i < 4; i++) step("to_mem_wait", MEMWR_W);
    bus.dmem_ready = 1'b1;
    step("halt0", HALTV);
    step("halt1", HALTV);

    // asynchronous reset out of HALT, mid-cycle
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", {29'b0, bus.state}, {29'b0, ST_IF});
    chk("arst_bus_err", {31'b0, bus.bus_err}, 32'd0);
    chk("arst_strobes", {23'b0, bus.imem_rd, bus.ir_wr, bus.pc_wr, bus.alu_en, bus.dmem_rd,
                         bus.dmem_wr, bus.reg_wr, bus.instr_done, bus.ir_wr}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_add("post_rst_add");

    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
